// File: rtl/monolith_pkg.sv
// Monolith Concrete layer shared types and M31 arithmetic helpers.
// MONOLITH_CONCRETE_RC_EN adds round-constant injection in the top.
package monolith_pkg;

  localparam int M31_W = 31;
  localparam int MDS_N = 16;
  localparam int ROW_W = $clog2(MDS_N);

  typedef logic [M31_W-1:0] m31_t;
  typedef m31_t m31_state_t [MDS_N];

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } fsm_e;

  localparam m31_t M31_P = 31'h7FFF_FFFF;

  localparam m31_state_t MDS_ROW = '{
    31'd1,  31'd1,  31'd51, 31'd1,
    31'd11, 31'd17, 31'd2,  31'd1,
    31'd101, 31'd63, 31'd15, 31'd2,
    31'd67, 31'd22, 31'd13, 31'd3
  };

  // Second fold absorbs the carry of the first, so one subtract suffices.
  function automatic m31_t m31_fold(input logic [61:0] x);
    logic [31:0] s;
    logic [31:0] t;
    s = {1'b0, x[30:0]} + {1'b0, x[61:31]};
    t = {1'b0, s[30:0]} + {31'b0, s[31]};
    if (t >= {1'b0, M31_P})
      m31_fold = 31'(t - {1'b0, M31_P});
    else
      m31_fold = t[30:0];
  endfunction

  function automatic m31_t m31_canon(input m31_t a);
    m31_canon = (a == M31_P) ? '0 : a;
  endfunction

  function automatic m31_t m31_add(input m31_t a, input m31_t b);
    m31_add = m31_fold({31'b0, a} + {31'b0, b});
  endfunction

endpackage

// File: rtl/m31_dot_row.sv
// Combinational 16-term dot product over GF(2^31-1).
// Products are reduced per term, then summed in a 35-bit accumulator.
module m31_dot_row
  import monolith_pkg::*;
(
  input  m31_t vec  [MDS_N],
  input  m31_t coef [MDS_N],
  output m31_t dot
);

  logic [34:0] acc;

  always_comb begin
    acc = '0;
    for (int j = 0; j < MDS_N; j++) begin
      acc = acc + {4'b0, m31_fold(
        62'(m31_canon(vec[j])) * 62'(coef[j]))};
    end
  end

  assign dot = m31_fold({27'b0, acc});

endmodule

// File: rtl/monolith_concrete.sv
// Monolith Concrete layer: circulant MDS multiply, one row per cycle.
// Define MONOLITH_CONCRETE_RC_EN to add rc_in into each output row.
module monolith_concrete
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] state_in [STATE_SIZE],
`ifdef MONOLITH_CONCRETE_RC_EN
  input  logic [WORD_WIDTH-1:0] rc_in [STATE_SIZE],
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] state_out [STATE_SIZE],
  output logic                  busy
);

  fsm_e             state_q;
  fsm_e             state_d;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] idx;
  logic             ov_q;
  logic             accept;
  logic             last;
  m31_t             in_q  [MDS_N];
  m31_t             out_q [MDS_N];
  m31_t             coef  [MDS_N];
  m31_t             dot;
  m31_t             row_val;
`ifdef MONOLITH_CONCRETE_RC_EN
  m31_t             rc_q  [MDS_N];
`endif

  assign accept = in_valid && in_ready;
  assign last   = row_q == ROW_W'(MDS_N - 1);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = S_COMPUTE;
      end
      S_COMPUTE: if (last) state_d = S_DONE;
      S_DONE: if (ov_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row r uses C rotated right by r: coef[j] = C[(j - r) mod N].
  always_comb begin
    idx = '0;
    for (int j = 0; j < MDS_N; j++) begin
      idx     = ROW_W'(j) - row_q;
      coef[j] = MDS_ROW[idx];
    end
  end

  m31_dot_row u_dot (
    .vec  (in_q),
    .coef (coef),
    .dot  (dot)
  );

`ifdef MONOLITH_CONCRETE_RC_EN
  assign row_val = m31_add(dot, m31_canon(rc_q[row_q]));
`else
  assign row_val = dot;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      ov_q    <= 1'b0;
      for (int j = 0; j < MDS_N; j++) begin
        in_q[j]  <= '0;
        out_q[j] <= '0;
`ifdef MONOLITH_CONCRETE_RC_EN
        rc_q[j]  <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      ov_q    <= (state_q == S_DONE) && !(ov_q && out_ready);
      if (accept) begin
        row_q <= '0;
        for (int j = 0; j < MDS_N; j++) begin
          in_q[j] <= m31_t'(state_in[j]);
`ifdef MONOLITH_CONCRETE_RC_EN
          rc_q[j] <= m31_t'(rc_in[j]);
`endif
        end
      end else if (state_q == S_COMPUTE) begin
        out_q[row_q] <= row_val;
        row_q        <= row_q + 1'b1;
      end
    end
  end

  assign out_valid = ov_q;

  always_comb begin
    for (int j = 0; j < STATE_SIZE; j++)
      state_out[j] = WORD_WIDTH'(out_q[j]);
  end

endmodule
